// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer with sticky trap and memory watchdog; optional RISCVIBE_INSTRET_EN adds a 64-bit instret.
// Latency: FENCE 2, BRANCH 3, ALU/jump/STORE 4, LOAD 5 cycles plus memory wait states.
// Backpressure: holds in FETCH/MEM until imem_ready/dmem_ready, traps if the wait reaches MAX_WAIT cycles.
package riscvibe_pkg;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_PC4, WB_IMM
    } reg_wr_src_t;
endpackage

module multicycle_control_unit
    import riscvibe_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [2:0]  mem_width,
    output logic        ir_load,
    output alu_op_t     alu_op,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        reg_write,
    output reg_wr_src_t reg_wr_src,
    output logic        pc_write,
    output logic        pc_src,
    output logic        instr_retired,
    output logic        halt,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state_o
`ifdef RISCVIBE_INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    state_t            state;
    logic [1:0]        cause_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic is_load, is_store, is_branch, is_jalr, is_jal, is_op_imm, is_op;
    logic is_lui, is_auipc, is_fence, is_system, is_legal;
    logic mem_rdy, timeout;
    logic unused_funct7;

    alu_op_t dec_alu_op;
    logic    dec_src_a, dec_src_b;

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_op_imm = (opcode == OPC_OP_IMM);
    assign is_op     = (opcode == OPC_OP);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_fence  = (opcode == OPC_FENCE);
    assign is_system = (opcode == OPC_SYSTEM);

    // Exact opcode match already rejects opcode[1:0] != 2'b11 (compressed space).
    assign is_legal = is_load | is_store | is_branch | is_jalr | is_jal | is_op_imm |
                      is_op | is_lui | is_auipc | is_fence | is_system;

    // Only funct7[5] distinguishes operations in RV32I base decode.
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    assign mem_rdy = (state == S_FETCH) ? imem_ready : dmem_ready;
    assign timeout = (MAX_WAIT > 0) && (wait_cnt == WAIT_LAST) && !mem_rdy;

    always_comb begin
        dec_alu_op = ALU_ADD;
        if (is_op || is_op_imm) begin
            case (funct3)
                3'd0:    dec_alu_op = (is_op && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'd1:    dec_alu_op = ALU_SLL;
                3'd2:    dec_alu_op = ALU_SLT;
                3'd3:    dec_alu_op = ALU_SLTU;
                3'd4:    dec_alu_op = ALU_XOR;
                3'd5:    dec_alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                3'd6:    dec_alu_op = ALU_OR;
                default: dec_alu_op = ALU_AND;
            endcase
        end
        dec_src_a = is_auipc | is_jal | is_branch;
        dec_src_b = !is_op;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            cause_q  <= 2'd0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        state    <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        state    <= S_TRAP;
                        cause_q  <= 2'd2;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (!is_legal) begin
                        state   <= S_TRAP;
                        cause_q <= 2'd1;
                    end else if (is_system) begin
                        state   <= S_TRAP;
                        cause_q <= 2'd3;
                    end else if (is_fence) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (is_load || is_store) state <= S_MEM;
                    else if (is_branch)      state <= S_FETCH;
                    else                     state <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        state    <= is_load ? S_WB : S_FETCH;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        state    <= S_TRAP;
                        cause_q  <= 2'd2;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        mem_width     = 3'd0;
        ir_load       = 1'b0;
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = 1'b0;
        reg_write     = 1'b0;
        reg_wr_src    = WB_ALU;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        instr_retired = 1'b0;
        halt          = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ready;
                end
                S_DECODE: begin
                    if (is_fence) begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                    end
                end
                S_EXECUTE: begin
                    alu_op    = dec_alu_op;
                    alu_src_a = dec_src_a;
                    alu_src_b = dec_src_b;
                    if (is_branch) begin
                        pc_write      = 1'b1;
                        pc_src        = branch_taken;
                        instr_retired = 1'b1;
                    end
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    dmem_we   = is_store;
                    mem_width = funct3;
                    if (dmem_ready && is_store) begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                    end
                end
                S_WB: begin
                    // ALU controls stay live so the JALR target is still on the ALU output.
                    alu_op        = dec_alu_op;
                    alu_src_a     = dec_src_a;
                    alu_src_b     = dec_src_b;
                    reg_write     = 1'b1;
                    pc_write      = 1'b1;
                    instr_retired = 1'b1;
                    pc_src        = is_jal | is_jalr;
                    if (is_load)                reg_wr_src = WB_MEM;
                    else if (is_jal || is_jalr) reg_wr_src = WB_PC4;
                    else if (is_lui)            reg_wr_src = WB_IMM;
                    else                        reg_wr_src = WB_ALU;
                end
                S_TRAP:  halt = 1'b1;
                default: halt = 1'b0;
            endcase
        end
    end

    assign trap_cause = rst ? 2'd0 : cause_q;
    assign state_o    = rst ? 3'd0 : state;

`ifdef RISCVIBE_INSTRET_EN
    always_ff @(posedge clk) begin
        if (rst)                instret <= 64'd0;
        else if (instr_retired) instret <= instret + 64'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit built with MAX_WAIT=4 so the watchdog boundary is reachable.
module tb_multicycle_control_unit;
    import riscvibe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic        branch_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_load;
    logic [2:0]  mem_width;
    alu_op_t     alu_op;
    logic        alu_src_a, alu_src_b, reg_write, pc_write, pc_src, instr_retired, halt;
    reg_wr_src_t reg_wr_src;
    logic [1:0]  trap_cause;
    logic [2:0]  state_o;
`ifdef RISCVIBE_INSTRET_EN
    logic [63:0] instret;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    multicycle_control_unit #(.MAX_WAIT(4), .WAIT_W(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .mem_width(mem_width),
        .ir_load(ir_load), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .reg_wr_src(reg_wr_src), .pc_write(pc_write), .pc_src(pc_src),
        .instr_retired(instr_retired), .halt(halt), .trap_cause(trap_cause), .state_o(state_o)
`ifdef RISCVIBE_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic [2:0] st, input logic ireq, input logic irl,
                       input logic rw, input logic pw, input logic ps, input logic ret);
        chk({tag, ".state"},     8'(state_o),       8'(st));
        chk({tag, ".imem_req"},  8'(imem_req),      8'(ireq));
        chk({tag, ".ir_load"},   8'(ir_load),       8'(irl));
        chk({tag, ".reg_write"}, 8'(reg_write),     8'(rw));
        chk({tag, ".pc_write"},  8'(pc_write),      8'(pw));
        chk({tag, ".pc_src"},    8'(pc_src),        8'(ps));
        chk({tag, ".retired"},   8'(instr_retired), 8'(ret));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drv(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic bt, input logic ir, input logic dr);
        opcode = op; funct3 = f3; funct7 = f7;
        branch_taken = bt; imem_ready = ir; dmem_ready = dr;
    endtask

    // Walks one register-writing instruction through FETCH, DECODE, EXECUTE, WB with no wait states.
    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input alu_op_t e_op, input logic e_a,
                           input logic e_b, input reg_wr_src_t e_src, input logic e_pcs);
        drv(op, f3, f7, 1'b0, 1'b1, 1'b0);
        #1 ctl({tag, ".F"}, 3'd0, 1, 1, 0, 0, 0, 0);
        step();
        #1 ctl({tag, ".D"}, 3'd1, 0, 0, 0, 0, 0, 0);
        step();
        #1 ctl({tag, ".E"}, 3'd2, 0, 0, 0, 0, 0, 0);
        chk({tag, ".E.alu_op"}, 8'(alu_op), 8'(e_op));
        chk({tag, ".E.src_a"},  8'(alu_src_a), 8'(e_a));
        chk({tag, ".E.src_b"},  8'(alu_src_b), 8'(e_b));
        step();
        #1 ctl({tag, ".W"}, 3'd4, 0, 0, 1, 1, e_pcs, 1);
        chk({tag, ".W.alu_op"}, 8'(alu_op), 8'(e_op));
        chk({tag, ".W.src_a"},  8'(alu_src_a), 8'(e_a));
        chk({tag, ".W.src_b"},  8'(alu_src_b), 8'(e_b));
        chk({tag, ".W.wr_src"}, 8'(reg_wr_src), 8'(e_src));
        step();
    endtask

    initial begin
        // Reset: every output held low while rst is high.
        step();
        #1 ctl("rst", 3'd0, 0, 0, 0, 0, 0, 0);
        chk("rst.halt", 8'(halt), 8'd0);
        chk("rst.trap_cause", 8'(trap_cause), 8'd0);
        step();
        rst = 1'b0;

        run_alu("addi",     7'b0010011, 3'd0, 7'b0000000, ALU_ADD, 0, 1, WB_ALU, 0);
        run_alu("addi_neg", 7'b0010011, 3'd0, 7'b1111111, ALU_ADD, 0, 1, WB_ALU, 0);
        run_alu("sub",      7'b0110011, 3'd0, 7'b0100000, ALU_SUB, 0, 0, WB_ALU, 0);
        run_alu("srai",     7'b0010011, 3'd5, 7'b0100000, ALU_SRA, 0, 1, WB_ALU, 0);
        run_alu("jal",      7'b1101111, 3'd0, 7'b0000000, ALU_ADD, 1, 1, WB_PC4, 1);
        run_alu("jalr",     7'b1100111, 3'd0, 7'b0000000, ALU_ADD, 0, 1, WB_PC4, 1);

        // LW with dmem_ready arriving on the 4th MEM cycle, the last one before the watchdog fires.
        drv(7'b0000011, 3'd2, 7'd0, 1'b0, 1'b1, 1'b0);
        #1 ctl("lw.F", 3'd0, 1, 1, 0, 0, 0, 0);
        step();
        #1 ctl("lw.D", 3'd1, 0, 0, 0, 0, 0, 0);
        step();
        #1 ctl("lw.E", 3'd2, 0, 0, 0, 0, 0, 0);
        chk("lw.E.src_b", 8'(alu_src_b), 8'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            #1 ctl("lw.M", 3'd3, 0, 0, 0, 0, 0, 0);
            chk("lw.M.dmem_req", 8'(dmem_req), 8'd1);
            chk("lw.M.dmem_we", 8'(dmem_we), 8'd0);
            chk("lw.M.width", 8'(mem_width), 8'd2);
            step();
        end
        dmem_ready = 1'b1;
        #1 ctl("lw.M4", 3'd3, 0, 0, 0, 0, 0, 0);
        chk("lw.M4.dmem_req", 8'(dmem_req), 8'd1);
        step();
        dmem_ready = 1'b0;
        #1 ctl("lw.W", 3'd4, 0, 0, 1, 1, 0, 1);
        chk("lw.W.wr_src", 8'(reg_wr_src), 8'(WB_MEM));
        step();

        // BEQ taken, then BNE not taken: both resolve in EXECUTE.
        drv(7'b1100011, 3'd0, 7'd0, 1'b1, 1'b1, 1'b0);
        #1 ctl("beq.F", 3'd0, 1, 1, 0, 0, 0, 0);
        step();
        #1 ctl("beq.D", 3'd1, 0, 0, 0, 0, 0, 0);
        step();
        #1 ctl("beq.E", 3'd2, 0, 0, 0, 1, 1, 1);
        step();
        drv(7'b1100011, 3'd1, 7'd0, 1'b0, 1'b1, 1'b0);
        #1 ctl("bne.F", 3'd0, 1, 1, 0, 0, 0, 0);
        step();
        #1 ctl("bne.D", 3'd1, 0, 0, 0, 0, 0, 0);
        step();
        #1 ctl("bne.E", 3'd2, 0, 0, 0, 1, 0, 1);
        step();

        // FENCE retires from DECODE.
        drv(7'b0001111, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0);
        #1 ctl("fence.F", 3'd0, 1, 1, 0, 0, 0, 0);
        step();
        #1 ctl("fence.D", 3'd1, 0, 0, 0, 1, 0, 1);
        step();
`ifdef RISCVIBE_INSTRET_EN
        #1 chk("instret", 8'(instret), 8'd10);
`endif

        // SW interrupted by rst while stalled in MEM.
        drv(7'b0100011, 3'd2, 7'd0, 1'b0, 1'b1, 1'b0);
        #1 ctl("sw.F", 3'd0, 1, 1, 0, 0, 0, 0);
        step();
        step();
        step();
        #1 ctl("sw.M", 3'd3, 0, 0, 0, 0, 0, 0);
        chk("sw.M.dmem_we", 8'(dmem_we), 8'd1);
        chk("sw.M.width", 8'(mem_width), 8'd2);
        step();
        rst = 1'b1;
        dmem_ready = 1'b1;
        #1 ctl("sw.rst", 3'd0, 0, 0, 0, 0, 0, 0);
        chk("sw.rst.dmem_req", 8'(dmem_req), 8'd0);
        step();
        rst = 1'b0;

        // Illegal opcode traps with cause 1 and stays there.
        drv(7'b0000000, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0);
        #1 ctl("rel.F", 3'd0, 1, 1, 0, 0, 0, 0);
        step();
        #1 ctl("ill.D", 3'd1, 0, 0, 0, 0, 0, 0);
        step();
        #1 ctl("ill.T", 3'd5, 0, 0, 0, 0, 0, 0);
        chk("ill.halt", 8'(halt), 8'd1);
        chk("ill.cause", 8'(trap_cause), 8'd1);
        step();
        #1 chk("ill.sticky", 8'(state_o), 8'd5);
        rst = 1'b1;
        #1 chk("ill.rst.halt", 8'(halt), 8'd0);
        chk("ill.rst.cause", 8'(trap_cause), 8'd0);
        step();
        rst = 1'b0;

        // ECALL traps with cause 3.
        drv(7'b1110011, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0);
        #1 ctl("ecall.F", 3'd0, 1, 1, 0, 0, 0, 0);
        chk("ecall.F.cause", 8'(trap_cause), 8'd0);
        step();
        step();
        #1 chk("ecall.state", 8'(state_o), 8'd5);
        chk("ecall.cause", 8'(trap_cause), 8'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // imem_ready never arrives: 4 FETCH cycles, then bus-timeout trap.
        drv(7'b0010011, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1 ctl("wd.F", 3'd0, 1, 0, 0, 0, 0, 0);
            step();
        end
        #1 ctl("wd.T", 3'd5, 0, 0, 0, 0, 0, 0);
        chk("wd.halt", 8'(halt), 8'd1);
        chk("wd.cause", 8'(trap_cause), 8'd2);
        imem_ready = 1'b1;
        step();
        #1 ctl("wd.sticky", 3'd5, 0, 0, 0, 0, 0, 0);
        chk("wd.sticky.cause", 8'(trap_cause), 8'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 ctl("wd.rel", 3'd0, 1, 1, 0, 0, 0, 0);
        chk("wd.rel.cause", 8'(trap_cause), 8'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
